// File: rtl/bcd_serial_addsub_pkg.sv
// Shared types and constants for the digit-serial packed-BCD adder/subtractor.
package bcd_serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [4:0] BCD_ADJ  = 5'd6;

  // Index counter needs at least one bit even for a single-digit build.
  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

  function automatic logic bcd_bad(input logic [3:0] d);
    return d > BCD_NINE;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decimal digit of add or nine's-complement subtract with +6 correction.
// Purely combinational; carry in/out are decimal carries.
module bcd_digit_cell
  import bcd_serial_addsub_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] s,
  output logic       cout,
  output logic       bad
);

  logic [3:0] bop;
  logic [4:0] t;

  always_comb begin
    bop  = sub ? (BCD_NINE - b) : b;
    t    = {1'b0, a} + {1'b0, bop} + {4'b0, cin};
    s    = t[3:0];
    cout = 1'b0;
    if (t > 5'd9) begin
      s    = t[3:0] + BCD_ADJ[3:0];
      cout = 1'b1;
    end
    bad = bcd_bad(a) | bcd_bad(b);
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Packed-BCD add/subtract, one digit per clock LSD first; done pulses DIGITS cycles after start.
// start is honoured only in IDLE; results hold until the next accepted start.
module bcd_serial_addsub
  import bcd_serial_addsub_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_in,
  input  logic                sub_in,
  input  logic [4*DIGITS-1:0] a_in,
  input  logic [4*DIGITS-1:0] b_in,
  input  logic                c_in,
  output logic [4*DIGITS-1:0] s_out,
  output logic                c_out,
  output logic                busy_out,
  output logic                done_out,
  output logic                err_out
);

  localparam int             IW   = idx_width(DIGITS);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t              state;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] a_q, b_q;
  logic                sub_q, carry_q, err_q;
  logic                cap_err;
  logic [3:0]          cell_s;
  logic                cell_cout, cell_bad;

  always_comb begin
    cap_err = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      cap_err = cap_err | bcd_bad(a_in[4*i +: 4]) | bcd_bad(b_in[4*i +: 4]);
  end

  bcd_digit_cell u_cell (
    .a    (a_q[idx*4 +: 4]),
    .b    (b_q[idx*4 +: 4]),
    .cin  (carry_q),
    .sub  (sub_q),
    .s    (cell_s),
    .cout (cell_cout),
    .bad  (cell_bad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      s_out    <= '0;
      c_out    <= 1'b0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      err_out  <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            a_q      <= a_in;
            b_q      <= b_in;
            sub_q    <= sub_in;
            // Subtraction runs as A + nines(B) + 1, so a borrow-in removes the +1.
            carry_q  <= c_in ^ sub_in;
            idx      <= '0;
            err_q    <= cap_err;
            s_out    <= '0;
            busy_out <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          s_out[idx*4 +: 4] <= cell_s;
          carry_q           <= cell_cout;
          err_q             <= err_q | cell_bad;
          if (idx == LAST) begin
            idx      <= '0;
            c_out    <= cell_cout;
            err_out  <= err_q | cell_bad;
            busy_out <= 1'b0;
            done_out <= 1'b1;
            state    <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub: 4-digit and 1-digit instances.
module tb_bcd_serial_addsub;

  logic        clk, rst;
  logic        start4, start1, sub, cin;
  logic [15:0] a4, b4;
  logic [15:0] s4;
  logic        c4, busy4, done4, err4;
  logic [3:0]  s1;
  logic        c1, busy1, done1, err1;

  int tests = 0;
  int fails = 0;

  bcd_serial_addsub #(.DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start_in(start4), .sub_in(sub),
    .a_in(a4), .b_in(b4), .c_in(cin),
    .s_out(s4), .c_out(c4), .busy_out(busy4), .done_out(done4), .err_out(err4)
  );

  bcd_serial_addsub #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .start_in(start1), .sub_in(sub),
    .a_in(a4[3:0]), .b_in(b4[3:0]), .c_in(cin),
    .s_out(s1), .c_out(c1), .busy_out(busy1), .done_out(done1), .err_out(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Launch one operation, then watch 12 cycles: latency is the number of edges after the capture edge.
  task automatic do_op(input bit one, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s,
                       output logic [15:0] r, output logic co, output logic eo,
                       output int lat, output int busy_n, output int done_n);
    r = '0; co = 1'b0; eo = 1'b0; lat = -1; busy_n = 0; done_n = 0;
    @(negedge clk);
    a4 = a; b4 = b; cin = c; sub = s;
    if (one) start1 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (n > 0) @(negedge clk);
      if (one ? busy1 : busy4) busy_n++;
      if (one ? done1 : done4) begin
        done_n++;
        if (lat < 0) begin
          lat = n;
          r   = one ? {12'h000, s1} : s4;
          co  = one ? c1 : c4;
          eo  = one ? err1 : err4;
        end
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] a, b;
    logic        c, s;
    logic [15:0] exp_s;
    logic        exp_c, exp_e;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [15:0] r;
    logic        co, eo;
    int          lat, bn, dn, cnt, first_n, second_n;
    logic [15:0] first_s, second_s;
    logic        busy5, busy6;

    vecs[0] = '{"add_basic",   16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{"add_ripple",  16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"add_cin",     16'h0999, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[3] = '{"sub_pos",     16'h5000, 16'h1234, 1'b0, 1'b1, 16'h3766, 1'b1, 1'b0};
    vecs[4] = '{"sub_neg",     16'h1234, 16'h5000, 1'b0, 1'b1, 16'h6234, 1'b0, 1'b0};
    vecs[5] = '{"invalid",     16'h00A0, 16'h0001, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b1};
    vecs[6] = '{"err_clear",   16'h0005, 16'h0005, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
    vecs[7] = '{"add_allcarry",16'h4999, 16'h5001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{"sub_equal",   16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{"sub_borrow",  16'h0000, 16'h0000, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0};

    rst = 1'b1; start4 = 1'b0; start1 = 1'b0; sub = 1'b0; cin = 1'b0;
    a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    check("reset_s4",    s4,    16'h0000);
    check("reset_flags4", {c4, busy4, done4, err4}, 4'b0000);
    check("reset_s1",    s1,    4'h0);
    check("reset_flags1", {c1, busy1, done1, err1}, 4'b0000);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, r, co, eo, lat, bn, dn);
      check({vecs[i].name, "_s"},    r,   vecs[i].exp_s);
      check({vecs[i].name, "_c"},    co,  vecs[i].exp_c);
      check({vecs[i].name, "_err"},  eo,  vecs[i].exp_e);
      check({vecs[i].name, "_lat"},  lat, 4);
      check({vecs[i].name, "_busy"}, bn,  4);
      check({vecs[i].name, "_done"}, dn,  1);
    end

    // start pulses during RUN and DONE must be dropped.
    @(negedge clk);
    a4 = 16'h1234; b4 = 16'h5678; cin = 1'b0; sub = 1'b0; start4 = 1'b1;
    cnt = 0; busy6 = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done4) cnt++;
      if (n == 7) busy6 = busy4;
      case (n)
        0: start4 = 1'b0;
        2: begin start4 = 1'b1; a4 = 16'h1111; end
        3: start4 = 1'b0;
        4: start4 = 1'b1;
        5: start4 = 1'b0;
        default: ;
      endcase
    end
    check("ignore_done_count", cnt, 1);
    check("ignore_result", s4, 16'h6912);
    check("ignore_no_restart", busy6, 1'b0);

    // start held high: next capture on the IDLE cycle after DONE.
    @(negedge clk);
    a4 = 16'h0001; b4 = 16'h0001; start4 = 1'b1;
    first_n = -1; second_n = -1; first_s = '0; second_s = '0; busy5 = 1'b1; busy6 = 1'b0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (n == 5) begin busy5 = busy4; a4 = 16'h0002; b4 = 16'h0003; end
      if (n == 6) busy6 = busy4;
      if (done4 && first_n < 0) begin first_n = n; first_s = s4; end
      else if (done4 && second_n < 0) begin second_n = n; second_s = s4; end
    end
    start4 = 1'b0;
    repeat (8) @(negedge clk);
    check("held_first_lat", first_n, 4);
    check("held_first_s", first_s, 16'h0002);
    check("held_idle_gap", busy5, 1'b0);
    check("held_recapture", busy6, 1'b1);
    check("held_second_lat", second_n, 10);
    check("held_second_s", second_s, 16'h0005);

    // Asynchronous reset after two digit steps.
    @(negedge clk);
    a4 = 16'h1234; b4 = 16'h5678; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy4", busy4, 1'b1);
    rst = 1'b1;
    #1;
    check("async_s4", s4, 16'h0000);
    check("async_flags4", {c4, busy4, done4, err4}, 4'b0000);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done4) cnt++;
    end
    check("abandon_no_done4", cnt, 0);
    do_op(1'b0, 16'h0005, 16'h0005, 1'b0, 1'b0, r, co, eo, lat, bn, dn);
    check("post_reset_s4", r, 16'h0010);
    check("post_reset_c4", co, 1'b0);
    check("post_reset_lat4", lat, 4);

    // Same scenario on the single-digit instance.
    @(negedge clk);
    a4 = 16'h0007; b4 = 16'h0008; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    check("pre_reset_busy1", busy1, 1'b1);
    rst = 1'b1;
    #1;
    check("async_flags1", {s1, c1, busy1, done1, err1}, 8'h00);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done1) cnt++;
    end
    check("abandon_no_done1", cnt, 0);
    do_op(1'b1, 16'h0005, 16'h0005, 1'b0, 1'b0, r, co, eo, lat, bn, dn);
    check("d1_s", r, 16'h0000);
    check("d1_c", co, 1'b1);
    check("d1_lat", lat, 1);
    check("d1_busy", bn, 1);
    check("d1_done", dn, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
